// File: rtl/wb_cp0_pkg.sv
// Shared constants and the MEM->WB bus layout for the writeback/CP0 stage.
package wb_cp0_pkg;

  // CP0 register numbers (select 0 only).
  localparam logic [7:0] CP0_BADVADDR = 8'd8;
  localparam logic [7:0] CP0_COUNT    = 8'd9;
  localparam logic [7:0] CP0_COMPARE  = 8'd11;
  localparam logic [7:0] CP0_STATUS   = 8'd12;
  localparam logic [7:0] CP0_CAUSE    = 8'd13;
  localparam logic [7:0] CP0_EPC      = 8'd14;

  // ExcCode values.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bus width and LSB offset of every field.
  localparam int WB_BUS_W       = 156;
  localparam int OFF_PC         = 0;
  localparam int OFF_ERET       = 32;
  localparam int OFF_BADVADDR   = 33;
  localparam int OFF_BD         = 65;
  localparam int OFF_EXC_CODE   = 66;
  localparam int OFF_EXC_VALID  = 71;
  localparam int OFF_CP0R_ADDR  = 72;
  localparam int OFF_MFC0       = 80;
  localparam int OFF_MTC0       = 81;
  localparam int OFF_MFLO       = 82;
  localparam int OFF_MFHI       = 83;
  localparam int OFF_LO_WRITE   = 84;
  localparam int OFF_HI_WRITE   = 85;
  localparam int OFF_LO_RESULT  = 86;
  localparam int OFF_MEM_RESULT = 118;
  localparam int OFF_WDEST      = 150;
  localparam int OFF_WEN        = 155;

  // Same layout as a packed struct; first member is the MSB.
  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        bd;
    logic [31:0] badvaddr;
    logic        eret;
    logic [31:0] pc;
  } wb_bus_t;

  // Return address for a trap: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/wb_cp0_if.sv
// Pipeline-side bundle of the writeback stage: MEM->WB bus in, commit/redirect out.
interface wb_cp0_if;
  logic                               WB_valid;
  logic [wb_cp0_pkg::WB_BUS_W-1:0]    MEM_WB_bus_r;
  logic                               rf_wen;
  logic [4:0]                         rf_wdest;
  logic [31:0]                        rf_wdata;
  logic                               WB_over;
  logic [32:0]                        exc_bus;
  logic                               cancel;
  logic [4:0]                         WB_wdest;

  modport master (
    output WB_valid, MEM_WB_bus_r,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, exc_bus, cancel, WB_wdest
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r,
    output rf_wen, rf_wdest, rf_wdata, WB_over, exc_bus, cancel, WB_wdest
  );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match sets TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_ti;
  logic          w_wrap;
  logic [31:0]   w_count_inc;
  logic          w_ti_set;

  assign w_wrap      = (r_presc == PW'(COUNT_DIV - 1));
  assign w_count_inc = r_count + 32'd1;
  // Only a real increment can match; a Count load never raises TI.
  assign w_ti_set    = w_wrap & ~i_count_we & (w_count_inc == r_compare);

  // Prescaler and Count; a software load of Count overrides the tick.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_count_we) begin
      r_count <= i_wdata;
      r_presc <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_count <= w_count_inc;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Compare register and TI; a match beats a simultaneous Compare write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_compare_we) r_compare <= i_wdata;
      if (w_ti_set)          r_ti <= 1'b1;
      else if (i_compare_we) r_ti <= 1'b0;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/wb_cp0.sv
// Writeback stage with CP0: commits RF/HI/LO, resolves exceptions and
// interrupts, and redirects fetch on trap or eret.
module wb_cp0 import wb_cp0_pkg::*; #(
  parameter logic [31:0] EXC_VECTOR = 32'd0,
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  wb_cp0_if.slave               bus,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           WB_pc,
  output logic [31:0]           HI_data,
  output logic [31:0]           LO_data,
  output logic                  timer_int
);

  wb_bus_t w_bus;
  assign w_bus = wb_bus_t'(bus.MEM_WB_bus_r);

  logic [NUM_HW_INT-1:0] r_hw_int;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [1:0]  r_ip_sw;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_ip_hw;
  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_take;
  logic        w_commit;
  logic        w_eret;
  logic        w_mtc0;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_cp0_rdata;

  // Hardware IP bits; the top line is shared with the timer.
  assign w_ip_hw   = 6'(r_hw_int) | {w_ti, 5'd0};
  assign w_ip      = {w_ip_hw, r_ip_sw};
  assign w_int_req = r_ie & ~r_exl & (|(w_ip & r_im));
  assign w_take    = bus.WB_valid & (w_int_req | w_bus.exc_valid);
  assign w_commit  = bus.WB_valid & ~w_take;
  assign w_eret    = w_commit & w_bus.eret;
  assign w_mtc0    = w_commit & w_bus.mtc0;

  assign w_status = {16'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_mtc0 & (w_bus.cp0r_addr == CP0_COUNT)),
    .i_compare_we (w_mtc0 & (w_bus.cp0r_addr == CP0_COMPARE)),
    .i_wdata      (w_bus.mem_result),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  // CP0 read mux for mfc0; unimplemented addresses read as zero.
  always_comb begin
    // NOTE: default first so no path leaves the output unassigned (no latch).
    w_cp0_rdata = '0;
    case (w_bus.cp0r_addr)
      CP0_BADVADDR: w_cp0_rdata = r_badvaddr;
      CP0_COUNT:    w_cp0_rdata = w_count;
      CP0_COMPARE:  w_cp0_rdata = w_compare;
      CP0_STATUS:   w_cp0_rdata = w_status;
      CP0_CAUSE:    w_cp0_rdata = w_cause;
      CP0_EPC:      w_cp0_rdata = r_epc;
      default:      w_cp0_rdata = '0;
    endcase
  end

  // Register-file write data selection.
  always_comb begin
    bus.rf_wdata = w_bus.mem_result;
    if (w_bus.mfhi)      bus.rf_wdata = r_hi;
    else if (w_bus.mflo) bus.rf_wdata = r_lo;
    else if (w_bus.mfc0) bus.rf_wdata = w_cp0_rdata;
  end

  // Fetch redirect: trap vector first, then return from exception.
  always_comb begin
    bus.exc_bus = '0;
    if (w_take)      bus.exc_bus = {1'b1, EXC_VECTOR};
    else if (w_eret) bus.exc_bus = {1'b1, r_epc};
  end

  // Hardware interrupt lines are sampled once before reaching IP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_hw_int <= '0;
    else         r_hw_int <= hw_int;
  end

  // CP0 architectural state: trap entry, eret, then software writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_ip_sw    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (w_take) begin
      r_exc_code <= w_int_req ? EXC_INT : w_bus.exc_code;
      r_exl      <= 1'b1;
      // A nested trap keeps the original return point.
      if (!r_exl) begin
        r_epc <= epc_of(w_bus.pc, w_bus.bd);
        r_bd  <= w_bus.bd;
      end
      if (!w_int_req && (w_bus.exc_code == EXC_ADEL || w_bus.exc_code == EXC_ADES))
        r_badvaddr <= w_bus.badvaddr;
    end else if (w_eret) begin
      r_exl <= 1'b0;
    end else if (w_mtc0) begin
      case (w_bus.cp0r_addr)
        CP0_STATUS: begin
          r_im  <= w_bus.mem_result[15:8];
          r_exl <= w_bus.mem_result[1];
          r_ie  <= w_bus.mem_result[0];
        end
        CP0_CAUSE: r_ip_sw <= w_bus.mem_result[9:8];
        CP0_EPC:   r_epc   <= w_bus.mem_result;
        default: ;
      endcase
    end
  end

  // HI/LO commit; a trapping instruction leaves both untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_commit && w_bus.hi_write) r_hi <= w_bus.mem_result;
      if (w_commit && w_bus.lo_write) r_lo <= w_bus.lo_result;
    end
  end

  assign bus.rf_wen   = w_bus.wen & w_commit;
  assign bus.rf_wdest = w_bus.wdest;
  assign bus.WB_over  = bus.WB_valid;
  assign bus.cancel   = bus.exc_bus[32];
  assign bus.WB_wdest = bus.WB_valid ? w_bus.wdest : 5'd0;
  assign WB_pc        = w_bus.pc;
  assign HI_data      = r_hi;
  assign LO_data      = r_lo;
  assign timer_int    = w_ti;

endmodule

// File: tb/tb_wb_cp0.sv
// Self-checking bench for wb_cp0: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural CP0 model.
module tb_wb_cp0;
  import wb_cp0_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          NHW = 6;
  localparam int          DIV = 2;
  localparam logic [4:0]  CODES [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

  logic           clk = 1'b0;
  logic           resetn;
  logic [NHW-1:0] hw_int;
  logic [31:0]    WB_pc, HI_data, LO_data;
  logic           timer_int;

  wb_cp0_if u_bus ();

  wb_cp0 #(.EXC_VECTOR(VEC), .NUM_HW_INT(NHW), .COUNT_DIV(DIV)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (u_bus),
    .hw_int    (hw_int),
    .WB_pc     (WB_pc),
    .HI_data   (HI_data),
    .LO_data   (LO_data),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, act, exp);
    end
  endtask

  // Behavioural CP0 state.
  logic [31:0]    m_status, m_epc, m_badv, m_hi, m_lo, m_count, m_compare;
  logic           m_bd, m_ti;
  logic [4:0]     m_exc;
  logic [1:0]     m_ipsw;
  logic [NHW-1:0] m_hw;
  int             m_presc;

  // Last observed combinational outputs of a step.
  logic [31:0] o_wdata;
  logic [32:0] o_exc;
  logic        o_wen, o_cancel;

  task automatic model_reset();
    m_status = '0; m_epc = '0; m_badv = '0; m_hi = '0; m_lo = '0;
    m_count = '0; m_compare = '0; m_bd = 1'b0; m_ti = 1'b0;
    m_exc = '0; m_ipsw = '0; m_hw = '0; m_presc = 0;
  endtask

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = {6'd0, m_ipsw};
    for (int i = 0; i < NHW; i++) ip[2+i] = m_hw[i];
    ip[7] = ip[7] | m_ti;
    return ip;
  endfunction

  function automatic logic [31:0] m_cp0(input logic [7:0] addr);
    case (addr)
      8'd8:    return m_badv;
      8'd9:    return m_count;
      8'd11:   return m_compare;
      8'd12:   return m_status;
      8'd13:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
      8'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive, check combinational outputs, advance the model at the edge.
  task automatic step(input logic valid, input wb_bus_t b);
    logic [7:0]  ip;
    logic        irq, take, commit, tick, cw, pw;
    logic [32:0] e_exc;
    logic [31:0] e_wdata;
    u_bus.WB_valid     = valid;
    u_bus.MEM_WB_bus_r = b;
    #1;
    ip     = m_ip();
    irq    = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 8'd0);
    take   = valid && (irq || b.exc_valid);
    commit = valid && !take;
    if (take)                  e_exc = {1'b1, VEC};
    else if (valid && b.eret)  e_exc = {1'b1, m_epc};
    else                       e_exc = '0;
    if (b.mfhi)      e_wdata = m_hi;
    else if (b.mflo) e_wdata = m_lo;
    else if (b.mfc0) e_wdata = m_cp0(b.cp0r_addr);
    else             e_wdata = b.mem_result;
    o_wdata = u_bus.rf_wdata; o_exc = u_bus.exc_bus;
    o_wen = u_bus.rf_wen; o_cancel = u_bus.cancel;
    check("rf_wen",    64'(u_bus.rf_wen),   64'(valid && b.wen && !take));
    check("rf_wdest",  64'(u_bus.rf_wdest), 64'(b.wdest));
    check("rf_wdata",  64'(u_bus.rf_wdata), 64'(e_wdata));
    check("WB_over",   64'(u_bus.WB_over),  64'(valid));
    check("exc_bus",   64'(u_bus.exc_bus),  64'(e_exc));
    check("cancel",    64'(u_bus.cancel),   64'(e_exc[32]));
    check("WB_wdest",  64'(u_bus.WB_wdest), 64'(valid ? b.wdest : 5'd0));
    check("WB_pc",     64'(WB_pc),          64'(b.pc));
    check("HI_data",   64'(HI_data),        64'(m_hi));
    check("LO_data",   64'(LO_data),        64'(m_lo));
    check("timer_int", 64'(timer_int),      64'(m_ti));
    @(posedge clk);
    cw = commit && b.mtc0 && (b.cp0r_addr == 8'd9);
    pw = commit && b.mtc0 && (b.cp0r_addr == 8'd11);
    tick = 1'b0;
    if (cw) begin
      m_count = b.mem_result; m_presc = 0;
    end else if (m_presc == DIV - 1) begin
      m_presc = 0; m_count = m_count + 32'd1; tick = (m_count == m_compare);
    end else begin
      m_presc++;
    end
    if (pw) m_compare = b.mem_result;
    if (tick)    m_ti = 1'b1;
    else if (pw) m_ti = 1'b0;
    if (take) begin
      m_exc = irq ? 5'd0 : b.exc_code;
      if (!m_status[1]) begin
        m_epc = b.bd ? b.pc - 32'd4 : b.pc;
        m_bd  = b.bd;
      end
      m_status[1] = 1'b1;
      if (!irq && (b.exc_code == 5'd4 || b.exc_code == 5'd5)) m_badv = b.badvaddr;
    end else if (valid && b.eret) begin
      m_status[1] = 1'b0;
    end
    if (commit && b.mtc0) begin
      case (b.cp0r_addr)
        8'd12:   m_status = b.mem_result & 32'h0000_FF03;
        8'd13:   m_ipsw   = b.mem_result[9:8];
        8'd14:   m_epc    = b.mem_result;
        default: ;
      endcase
    end
    if (commit && b.hi_write) m_hi = b.mem_result;
    if (commit && b.lo_write) m_lo = b.lo_result;
    m_hw = hw_int;
    @(negedge clk);
  endtask

  task automatic do_mtc0(input logic [7:0] addr, input logic [31:0] data);
    wb_bus_t b;
    b = '0; b.mtc0 = 1'b1; b.cp0r_addr = addr; b.mem_result = data; b.pc = 32'h40;
    step(1'b1, b);
  endtask

  task automatic do_mfc0(input logic [7:0] addr);
    wb_bus_t b;
    b = '0; b.mfc0 = 1'b1; b.wen = 1'b1; b.wdest = 5'd3; b.cp0r_addr = addr; b.pc = 32'h44;
    step(1'b1, b);
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                        input logic bd, input logic [31:0] badv);
    wb_bus_t b;
    b = '0; b.wen = 1'b1; b.wdest = 5'd7; b.exc_valid = 1'b1;
    b.exc_code = code; b.pc = pc; b.bd = bd; b.badvaddr = badv;
    step(1'b1, b);
  endtask

  task automatic do_eret();
    wb_bus_t b;
    b = '0; b.eret = 1'b1; b.pc = 32'h48;
    step(1'b1, b);
  endtask

  task automatic do_nop(input logic valid);
    wb_bus_t b;
    b = '0; b.wen = valid; b.wdest = 5'd9; b.mem_result = 32'h5A5A_0001; b.pc = 32'h4C;
    step(valid, b);
  endtask

  function automatic wb_bus_t rand_bus();
    wb_bus_t b;
    int sel;
    b = '0;
    b.wen        = 1'($urandom_range(0, 1));
    b.wdest      = 5'($urandom_range(0, 31));
    b.mem_result = $urandom;
    b.lo_result  = $urandom;
    b.hi_write   = ($urandom_range(0, 3) == 0);
    b.lo_write   = ($urandom_range(0, 3) == 0);
    sel = int'($urandom_range(0, 7));
    b.mfhi = (sel == 0);
    b.mflo = (sel == 1);
    b.mfc0 = (sel == 2 || sel == 3);
    b.mtc0 = (sel == 4);
    b.eret = (sel == 5);
    case ($urandom_range(0, 6))
      0: b.cp0r_addr = 8'd8;
      1: b.cp0r_addr = 8'd9;
      2: b.cp0r_addr = 8'd11;
      3: b.cp0r_addr = 8'd12;
      4: b.cp0r_addr = 8'd13;
      5: b.cp0r_addr = 8'd14;
      default: b.cp0r_addr = 8'($urandom_range(0, 255));
    endcase
    if (b.mtc0 && b.cp0r_addr == 8'd9) b.mem_result = m_compare - 32'($urandom_range(1, 6));
    b.exc_valid = ($urandom_range(0, 9) == 0);
    b.exc_code  = CODES[$urandom_range(0, 5)];
    b.bd        = 1'($urandom_range(0, 1));
    b.badvaddr  = $urandom;
    b.pc        = $urandom & 32'hFFFF_FFFC;
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    wb_bus_t b;
    resetn = 1'b0;
    hw_int = '0;
    u_bus.WB_valid = 1'b0;
    u_bus.MEM_WB_bus_r = '0;
    model_reset();
    #1;
    check("rst_rf_wen",  64'(u_bus.rf_wen),   64'd0);
    check("rst_exc_bus", 64'(u_bus.exc_bus),  64'd0);
    check("rst_cancel",  64'(u_bus.cancel),   64'd0);
    check("rst_WB_over", 64'(u_bus.WB_over),  64'd0);
    check("rst_HI",      64'(HI_data),        64'd0);
    check("rst_LO",      64'(LO_data),        64'd0);
    check("rst_timer",   64'(timer_int),      64'd0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Every CP0 register reads zero out of reset.
    do_mfc0(8'd12); do_mfc0(8'd13); do_mfc0(8'd14); do_mfc0(8'd8);

    // mtc0 Status then immediate read-back.
    do_mtc0(8'd12, 32'h0000_0101);
    do_mfc0(8'd12);
    check("status_rb", 64'(o_wdata), 64'h101);

    // Syscall, then eret.
    do_exc(5'd8, 32'h100, 1'b0, 32'h0);
    check("sys_exc_bus", 64'(o_exc), {31'd0, 1'b1, VEC});
    check("sys_cancel",  64'(o_cancel), 64'd1);
    check("sys_rf_wen",  64'(o_wen), 64'd0);
    do_mfc0(8'd14); check("sys_epc", 64'(o_wdata), 64'h100);
    do_mfc0(8'd13); check("sys_code", 64'(o_wdata[6:2]), 64'd8);
    do_mfc0(8'd12); check("sys_exl", 64'(o_wdata[1]), 64'd1);
    do_eret();
    check("eret_bus", 64'(o_exc), {31'd0, 1'b1, 32'h100});
    do_mfc0(8'd12); check("eret_exl", 64'(o_wdata[1]), 64'd0);

    // AdEL in a delay slot, then a nested exception.
    do_exc(5'd4, 32'h204, 1'b1, 32'h1003);
    do_mfc0(8'd14); check("adel_epc", 64'(o_wdata), 64'h200);
    do_mfc0(8'd13); check("adel_bd", 64'(o_wdata[31]), 64'd1);
    do_mfc0(8'd8);  check("adel_badv", 64'(o_wdata), 64'h1003);
    do_exc(5'd8, 32'h300, 1'b0, 32'h0);
    do_mfc0(8'd14); check("nested_epc", 64'(o_wdata), 64'h200);
    do_eret();

    // Timer interrupt.
    do_mtc0(8'd11, 32'd5);
    do_mtc0(8'd12, 32'h0000_8001);
    do_mtc0(8'd9, 32'd0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      do_nop(1'b0);
      if (timer_int) k = i;
    end
    check("ti_latency", 64'(k), 64'd10);
    do_nop(1'b1);
    check("ti_trap", 64'(o_exc), {31'd0, 1'b1, VEC});
    do_mfc0(8'd13); check("ti_code", 64'(o_wdata[6:2]), 64'd0);
    do_mtc0(8'd11, 32'h1000_0000);
    check("ti_clear", 64'(timer_int), 64'd0);
    do_eret();

    // Hardware interrupt masked, then unmasked.
    do_mtc0(8'd12, 32'h0000_0001);
    hw_int = 6'b000001;
    do_nop(1'b1); check("hw_masked1", 64'(o_exc[32]), 64'd0);
    do_nop(1'b1); check("hw_masked2", 64'(o_exc[32]), 64'd0);
    do_mtc0(8'd12, 32'h0000_0401);
    do_nop(1'b1); check("hw_trap", 64'(o_exc[32]), 64'd1);
    do_mfc0(8'd13); check("hw_ip2_hi", 64'(o_wdata[10]), 64'd1);
    hw_int = '0;
    do_nop(1'b0);
    do_mfc0(8'd13); check("hw_ip2_lo", 64'(o_wdata[10]), 64'd0);
    do_eret();

    // HI write suppressed by a same-cycle exception.
    do_mtc0(8'd12, 32'h0);
    b = '0; b.hi_write = 1'b1; b.mem_result = 32'h1234; step(1'b1, b);
    b = '0; b.hi_write = 1'b1; b.mem_result = 32'hDEAD; b.exc_valid = 1'b1; b.exc_code = 5'd12;
    step(1'b1, b);
    check("hi_kept", 64'(HI_data), 64'h1234);
    do_eret();

    // Count load coinciding with a prescaler wrap.
    for (int i = 0; i < DIV && m_presc != DIV - 1; i++) do_nop(1'b0);
    do_mtc0(8'd9, 32'd7);
    do_mfc0(8'd9); check("count_load", 64'(o_wdata), 64'd7);

    // Asynchronous reset in mid-cycle.
    @(negedge clk);
    u_bus.WB_valid = 1'b1;
    b = '0; b.mfc0 = 1'b1; b.cp0r_addr = 8'd9; u_bus.MEM_WB_bus_r = b;
    #3 resetn = 1'b0;
    #1;
    check("arst_count", 64'(u_bus.rf_wdata), 64'd0);
    check("arst_HI",    64'(HI_data),        64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) hw_int = NHW'($urandom_range(0, (1 << NHW) - 1));
      step(1'($urandom_range(0, 3) != 0), rand_bus());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
